// File: rtl/prbs16_pkg.sv
// Shared PRBS16 definitions (x^16+x^13+x^12+x^11+1, Fibonacci, shift-left).
// Used by both the generator and the checker so they cannot drift apart.
package prbs16_pkg;

    typedef logic [15:0] prbs_word_t;

    // Tap mask selects word bits 15, 12, 11 and 10.
    localparam prbs_word_t PRBS16_TAPS = 16'h9C00;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    function automatic prbs_word_t prbs16_next(input prbs_word_t w);
        return {w[14:0], ^(w & PRBS16_TAPS)};
    endfunction

endpackage

// File: rtl/prbs16_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: hunts for the sequence, locks after a run of correct
// predictions, then flywheels the prediction and counts mismatched words.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_MATCHES = 4,
    parameter int LOSS_MISSES  = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [15:0]      inSeq,
    input  logic             clrCnt,
    output logic             locked,
    output logic             errPulse,
    output logic [CNT_W-1:0] errCount,
    output logic [CNT_W-1:0] wordCount
);

    localparam int MR_W = $clog2(LOCK_MATCHES + 1);
    localparam int MS_W = $clog2(LOSS_MISSES + 1);

    logic [0:0]      state_q,     state_d;
    logic            have_ref_q,  have_ref_d;
    logic [MR_W-1:0] match_run_q, match_run_d;
    logic [MS_W-1:0] miss_run_q,  miss_run_d;
    prbs_word_t      exp_q,       exp_d;
    logic            locked_q,    locked_d;
    logic            err_pulse_q, err_pulse_d;
    logic            err_inc_s;
    logic            word_inc_s;
    logic [MR_W-1:0] match_inc_s;
    logic [MS_W-1:0] miss_inc_s;

    assign match_inc_s = match_run_q + MR_W'(1);
    assign miss_inc_s  = miss_run_q + MS_W'(1);

    // Hunt/lock state machine and prediction update for one received word.
    always_comb begin
        state_d     = state_q;
        have_ref_d  = have_ref_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        exp_d       = exp_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_inc_s   = 1'b0;
        word_inc_s  = 1'b0;
        if (inValid) begin
            case (state_q)
                ST_HUNT: begin
                    if (inSeq == 16'h0000) begin
                        have_ref_d  = 1'b0;
                        match_run_d = {MR_W{1'b0}};
                    end else begin
                        exp_d      = prbs16_next(inSeq);
                        have_ref_d = 1'b1;
                        if (have_ref_q && (inSeq == exp_q)) begin
                            if (match_inc_s == MR_W'(LOCK_MATCHES)) begin
                                state_d     = ST_LOCKED;
                                locked_d    = 1'b1;
                                miss_run_d  = {MS_W{1'b0}};
                                match_run_d = {MR_W{1'b0}};
                            end else begin
                                match_run_d = match_inc_s;
                            end
                        end else begin
                            match_run_d = {MR_W{1'b0}};
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the prediction advances from itself, never from inSeq.
                    exp_d      = prbs16_next(exp_q);
                    word_inc_s = 1'b1;
                    if (inSeq == exp_q) begin
                        miss_run_d = {MS_W{1'b0}};
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc_s   = 1'b1;
                        if (miss_inc_s == MS_W'(LOSS_MISSES)) begin
                            state_d     = ST_HUNT;
                            locked_d    = 1'b0;
                            match_run_d = {MR_W{1'b0}};
                            miss_run_d  = {MS_W{1'b0}};
                            exp_d       = prbs16_next(inSeq);
                            have_ref_d  = (inSeq != 16'h0000);
                        end else begin
                            miss_run_d = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            have_ref_q  <= 1'b0;
            match_run_q <= {MR_W{1'b0}};
            miss_run_q  <= {MS_W{1'b0}};
            exp_q       <= 16'h0000;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_ref_q  <= have_ref_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            exp_q       <= exp_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clrCnt),
        .inc (err_inc_s),
        .q   (errCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clrCnt),
        .inc (word_inc_s),
        .q   (wordCount)
    );

    assign locked   = locked_q;
    assign errPulse = err_pulse_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Table-driven bench for prbs16_checker with a small expected-result queue;
// a second instance uses 4-bit counters and a long loss threshold for saturation.
module tb_prbs16_checker;

    typedef enum int {M_GOOD, M_FLIP, M_ZERO, M_IDLE, M_RST} mode_e;

    typedef struct {
        mode_e mode;
        bit    clr;
        bit    lk;
        bit    pl;
        int    ec;
        int    wc;
    } vec_t;

    typedef struct {
        int tag;
        bit lk;
        bit pl;
        int ec;
        int wc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, val_a = 1'b0, clr_a = 1'b0;
    logic [15:0] seq_a = 16'h0000;
    logic        lk_a, pl_a;
    logic [15:0] ec_a, wc_a;
    logic        rst_b = 1'b0, val_b = 1'b0, clr_b = 1'b0;
    logic [15:0] seq_b = 16'h0000;
    logic        lk_b, pl_b;
    logic [3:0]  ec_b, wc_b;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tag = 0;
    logic [15:0] gen;

    always #5 clk = ~clk;

    prbs16_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .inValid(val_a), .inSeq(seq_a), .clrCnt(clr_a),
        .locked(lk_a), .errPulse(pl_a), .errCount(ec_a), .wordCount(wc_a)
    );

    prbs16_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(31), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .inValid(val_b), .inSeq(seq_b), .clrCnt(clr_b),
        .locked(lk_b), .errPulse(pl_b), .errCount(ec_b), .wordCount(wc_b)
    );

    function automatic logic [15:0] gen_next(input logic [15:0] w);
        return {w[14:0], w[15] ^ w[12] ^ w[11] ^ w[10]};
    endfunction

    function automatic vec_t mk(input mode_e m, input bit c, input bit l, input bit p,
                                input int e, input int w);
        vec_t v;
        v.mode = m; v.clr = c; v.lk = l; v.pl = p; v.ec = e; v.wc = w;
        return v;
    endfunction

    task automatic step(input int dut, input vec_t v);
        exp_t        e;
        logic [15:0] s;
        logic        vld;
        logic        r;
        int          al, ap, ae, aw;
        vld = 1'b1;
        r   = 1'b1;
        s   = gen;
        case (v.mode)
            M_GOOD: gen = gen_next(gen);
            M_FLIP: begin s = gen ^ 16'h0001; gen = gen_next(gen); end
            M_ZERO: s = 16'h0000;
            M_IDLE: begin vld = 1'b0; s = 16'($urandom); end
            M_RST:  r = 1'b0;
            default: vld = 1'b0;
        endcase
        if (dut == 1) begin
            rst_a = r; val_a = vld; seq_a = s; clr_a = v.clr;
        end else begin
            rst_b = r; val_b = vld; seq_b = s; clr_b = v.clr;
        end
        e.tag = tag; e.lk = v.lk; e.pl = v.pl; e.ec = v.ec; e.wc = v.wc;
        sb.push_back(e);
        tag++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (dut == 1) begin
            al = int'(lk_a); ap = int'(pl_a); ae = int'(ec_a); aw = int'(wc_a);
        end else begin
            al = int'(lk_b); ap = int'(pl_b); ae = int'(ec_b); aw = int'(wc_b);
        end
        n_cmp++;
        if (al != int'(e.lk) || ap != int'(e.pl) || ae != e.ec || aw != e.wc) begin
            n_bad++;
            $display("FAIL step%0d dut%0d: got locked=%0d pulse=%0d err=%0d words=%0d, want locked=%0d pulse=%0d err=%0d words=%0d",
                     e.tag, dut, al, ap, ae, aw, e.lk, e.pl, e.ec, e.wc);
        end
    endtask

    initial begin
        // Reset state of the main instance.
        step(1, mk(M_RST, 1'b0, 1'b0, 1'b0, 0, 0));

        // Lock, single error with flywheel, loss and relock, zero word in HUNT, clear.
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 0, 0));
        tbl.push_back(mk(M_FLIP, 0, 1, 1, 1, 1));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 1, 2));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 1, 3));
        tbl.push_back(mk(M_IDLE, 0, 1, 0, 1, 3));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 1, 4));
        tbl.push_back(mk(M_FLIP, 0, 1, 1, 2, 5));
        tbl.push_back(mk(M_FLIP, 0, 1, 1, 3, 6));
        tbl.push_back(mk(M_FLIP, 0, 0, 1, 4, 7));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 4, 7));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 4, 7));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 4, 7));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 4, 7));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 4, 7));
        tbl.push_back(mk(M_FLIP, 0, 1, 1, 5, 8));
        tbl.push_back(mk(M_FLIP, 0, 1, 1, 6, 9));
        tbl.push_back(mk(M_FLIP, 0, 0, 1, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_ZERO, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_IDLE, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_IDLE, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 0, 0, 7, 10));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 7, 10));
        tbl.push_back(mk(M_IDLE, 1, 1, 0, 0, 0));
        tbl.push_back(mk(M_FLIP, 1, 1, 1, 0, 0));
        tbl.push_back(mk(M_GOOD, 0, 1, 0, 0, 1));

        gen = 16'hACE1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(1, tbl[i]);
        end

        // Reset pulse while locked, then relock with random idle gaps.
        step(1, mk(M_RST, 1'b0, 1'b0, 1'b0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            int gaps;
            gaps = int'($urandom_range(0, 7));
            for (int g = 0; g < gaps; g++) begin
                step(1, mk(M_IDLE, 1'b0, (k > 5), 1'b0, 0, (k > 5) ? k - 6 : 0));
            end
            step(1, mk(M_GOOD, 1'b0, (k >= 5), 1'b0, 0, (k > 5) ? k - 5 : 0));
        end

        // Narrow counters: saturation at 15 and clear against a concurrent error.
        gen = 16'hACE1;
        step(2, mk(M_RST, 1'b0, 1'b0, 1'b0, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            step(2, mk(M_GOOD, 1'b0, (k == 5), 1'b0, 0, 0));
        end
        for (int k = 1; k <= 20; k++) begin
            step(2, mk(M_FLIP, 1'b0, 1'b1, 1'b1, (k > 15) ? 15 : k, (k > 15) ? 15 : k));
        end
        step(2, mk(M_FLIP, 1'b1, 1'b1, 1'b1, 0, 0));
        step(2, mk(M_GOOD, 1'b0, 1'b1, 1'b0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
